// File: rtl/mem_pkg.sv
// Shared types for the data-memory side of the pipeline: store-buffer entry,
// store-buffer state encoding and the word-address boundary.
package mem_pkg;

  localparam int WORD_LSB = 2;

  typedef struct packed {
    logic [31:0] addr;
    logic [31:0] data;
    logic [31:0] pc;
  } sb_entry_t;

  typedef enum logic [0:0] {
    SB_RUN,
    SB_FLUSH
  } sb_state_t;

endpackage

// File: rtl/store_buffer_if.sv
// Store/load/memory-port bundle between the MEM stage, the store buffer and the
// data memory. The slave side is the store buffer itself.
interface store_buffer_if;

  logic        st_valid;
  logic        st_ready;
  logic [31:0] st_addr;
  logic [31:0] st_data;
  logic [31:0] st_pc;

  logic        ld_valid;
  logic [31:0] ld_addr;
  logic [31:0] ld_data;
  logic        ld_stall;

  logic        drain_req;
  logic        empty;

  logic        dm_wr;
  logic [31:0] dm_addr;
  logic [31:0] dm_wd;
  logic [31:0] dm_pc;
  logic [31:0] dm_rd;

  modport master (
    output st_valid, st_addr, st_data, st_pc,
    output ld_valid, ld_addr, drain_req, dm_rd,
    input  st_ready, ld_data, ld_stall, empty,
    input  dm_wr, dm_addr, dm_wd, dm_pc
  );

  modport slave (
    input  st_valid, st_addr, st_data, st_pc,
    input  ld_valid, ld_addr, drain_req, dm_rd,
    output st_ready, ld_data, ld_stall, empty,
    output dm_wr, dm_addr, dm_wd, dm_pc
  );

endinterface

// File: rtl/sb_match.sv
// Youngest-first word-address search over the live store-buffer entries,
// walking from wr_ptr-1 back towards rd_ptr (count entries).
module sb_match
  import mem_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int PTR_W = 2
) (
  input  logic [31:WORD_LSB] entry_addr [DEPTH],
  input  logic [31:0]        entry_data [DEPTH],
  input  logic [PTR_W-1:0]   wr_ptr,
  input  logic [PTR_W:0]     count,
  input  logic [31:WORD_LSB] addr,
  output logic               hit,
  output logic [31:0]        hit_data
);

  logic [PTR_W-1:0] idx;

  // The first hit found while walking backwards is the youngest; later
  // (older) hits are ignored.
  always_comb begin
    // NOTE: every output and temporary gets a default before the loop so no
    // path leaves it unassigned, which would otherwise infer a latch.
    hit      = 1'b0;
    hit_data = '0;
    idx      = '0;
    for (int k = 0; k < DEPTH; k++) begin
      idx = wr_ptr - PTR_W'(k + 1);
      if (!hit && (k < int'(count)) && (entry_addr[idx] == addr)) begin
        hit      = 1'b1;
        hit_data = entry_data[idx];
      end
    end
  end

endmodule

// File: rtl/store_buffer.sv
// store_buffer: word-store FIFO draining into the data memory's single port in load-free cycles.
// Build macro STORE_BUFFER_FORWARD_EN: hitting loads get forwarded data; otherwise they stall.
module store_buffer
  import mem_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int PTR_W = 2
) (
  input  logic          CLK,
  input  logic          Reset,
  store_buffer_if.slave sb
);

  localparam logic [PTR_W:0]   FULL_CNT = (PTR_W + 1)'(DEPTH);
  localparam logic [PTR_W:0]   CNT_ONE  = (PTR_W + 1)'(1);
  localparam logic [PTR_W-1:0] PTR_ONE  = PTR_W'(1);

  sb_entry_t          entries_q [DEPTH];
  logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
  logic [PTR_W:0]     count_q, count_d;
  sb_state_t          state_q, state_d;
  logic               st_ready_q, st_ready_d;
  logic               empty_q, empty_d;

  logic               enq;
  logic               deq;
  logic               hit;
  logic               ld_port;
  sb_entry_t          head;
  logic [31:WORD_LSB] match_addr [DEPTH];
  logic [31:0]        match_data [DEPTH];

  assign head = entries_q[rd_ptr_q];
  assign enq  = sb.st_valid && st_ready_q;

  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
      match_addr[i] = entries_q[i].addr[31:WORD_LSB];
      match_data[i] = entries_q[i].data;
    end
  end

`ifdef STORE_BUFFER_FORWARD_EN
  logic [31:0] fwd_data;
`else
  logic [31:0] fwd_data_unused;
`endif

  sb_match #(
    .DEPTH (DEPTH),
    .PTR_W (PTR_W)
  ) u_match (
    .entry_addr (match_addr),
    .entry_data (match_data),
    .wr_ptr     (wr_ptr_q),
    .count      (count_q),
    .addr       (sb.ld_addr[31:WORD_LSB]),
    .hit        (hit),
`ifdef STORE_BUFFER_FORWARD_EN
    .hit_data   (fwd_data)
`else
    .hit_data   (fwd_data_unused)
`endif
  );

`ifdef STORE_BUFFER_FORWARD_EN
  assign ld_port     = sb.ld_valid;
  assign sb.ld_stall = 1'b0;
  assign sb.ld_data  = hit ? fwd_data : sb.dm_rd;
`else
  // A load that hits a pending store gives up the port so the hit can drain.
  assign ld_port     = sb.ld_valid && !hit;
  assign sb.ld_stall = sb.ld_valid && hit;
  assign sb.ld_data  = sb.dm_rd;
`endif

  assign deq        = (count_q != '0) && !ld_port;
  assign sb.dm_wr   = deq;
  assign sb.dm_addr = ld_port ? sb.ld_addr : (deq ? head.addr : '0);
  assign sb.dm_wd   = deq ? head.data : '0;
  assign sb.dm_pc   = deq ? head.pc   : '0;
  assign sb.st_ready = st_ready_q;
  assign sb.empty    = empty_q;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    state_d  = state_q;
    if (enq) wr_ptr_d = wr_ptr_q + PTR_ONE;
    if (deq) rd_ptr_d = rd_ptr_q + PTR_ONE;
    case ({enq, deq})
      2'b10:   count_d = count_q + CNT_ONE;
      2'b01:   count_d = count_q - CNT_ONE;
      default: count_d = count_q;
    endcase
    case (state_q)
      SB_RUN:   if (sb.drain_req) state_d = SB_FLUSH;
      SB_FLUSH: if ((count_q == '0) && !sb.drain_req) state_d = SB_RUN;
      default:  state_d = SB_RUN;
    endcase
    // Registered from next-state so a drain into a full buffer only frees a
    // slot from the following cycle on.
    st_ready_d = (state_d == SB_RUN) && (count_d != FULL_CNT);
    empty_d    = (count_d == '0);
  end

  always_ff @(posedge CLK) begin
    if (!Reset) begin
      // NOTE: sequential state is written with <= so all flops sample pre-edge
      // values; blocking assignments here would make results order-dependent.
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      state_q    <= SB_RUN;
      st_ready_q <= 1'b1;
      empty_q    <= 1'b1;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      state_q    <= state_d;
      st_ready_q <= st_ready_d;
      empty_q    <= empty_d;
    end
  end

  // NOTE: the entry array has no reset; count/pointers define which slots are
  // live, so stale contents are never observed.
  always_ff @(posedge CLK) begin
    if (enq) begin
      entries_q[wr_ptr_q] <= '{addr: sb.st_addr, data: sb.st_data, pc: sb.st_pc};
    end
  end

endmodule

// File: tb/tb_store_buffer.sv
// Self-checking bench for store_buffer: scoreboard of accepted stores checked
// against every memory write, plus directed checks of reset, backpressure,
// forwarding/stall, flush and pointer wrap-around.
module tb_store_buffer;
  import mem_pkg::*;

  logic CLK;
  logic Reset;

  store_buffer_if sb_if ();

  store_buffer #(
    .DEPTH (4),
    .PTR_W (2)
  ) dut (
    .CLK   (CLK),
    .Reset (Reset),
    .sb    (sb_if.slave)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // Word-addressed data memory with combinational read.
  logic [31:0] mem [256];
  assign sb_if.dm_rd = mem[sb_if.dm_addr[9:2]];
  always @(posedge CLK) begin
    if (sb_if.dm_wr) mem[sb_if.dm_addr[9:2]] = sb_if.dm_wd;
  end

  int        checks = 0;
  int        errors = 0;
  int        drains = 0;
  sb_entry_t exp_q [$];
  sb_entry_t exp_e;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Scoreboard: accepted stores are pushed, each memory write pops and compares.
  always @(negedge CLK) begin
    if (Reset) begin
      if (sb_if.dm_wr) begin
        drains++;
        if (exp_q.size() == 0) begin
          check("spurious_dm_wr", {31'b0, sb_if.dm_wr}, 32'd0);
        end else begin
          exp_e = exp_q.pop_front();
          check("sb_dm_addr", sb_if.dm_addr, exp_e.addr);
          check("sb_dm_wd",   sb_if.dm_wd,   exp_e.data);
          check("sb_dm_pc",   sb_if.dm_pc,   exp_e.pc);
        end
      end
      if (sb_if.st_valid && sb_if.st_ready) begin
        exp_q.push_back('{addr: sb_if.st_addr, data: sb_if.st_data, pc: sb_if.st_pc});
      end
    end
  end

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic store(input logic [31:0] a, input logic [31:0] d, input logic [31:0] p);
    sb_if.st_valid = 1'b1;
    sb_if.st_addr  = a;
    sb_if.st_data  = d;
    sb_if.st_pc    = p;
    step();
    sb_if.st_valid = 1'b0;
  endtask

  task automatic wait_drain(input string tag);
    int n;
    n = 0;
    @(negedge CLK);
    while (!sb_if.empty && n < 50) begin
      n++;
      @(negedge CLK);
    end
    check({tag, "_drained"}, {31'b0, sb_if.empty}, 32'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation still running, expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int n;
    int d0;
    Reset           = 1'b0;
    sb_if.st_valid  = 1'b0;
    sb_if.st_addr   = '0;
    sb_if.st_data   = '0;
    sb_if.st_pc     = '0;
    sb_if.ld_valid  = 1'b0;
    sb_if.ld_addr   = '0;
    sb_if.drain_req = 1'b0;
    for (int i = 0; i < 256; i++) mem[i] = '0;
    mem[9] = 32'hDEAD_BEEF;

    // Reset state
    repeat (2) step();
    @(negedge CLK);
    check("rst_empty",    {31'b0, sb_if.empty},    32'd1);
    check("rst_st_ready", {31'b0, sb_if.st_ready}, 32'd1);
    check("rst_dm_wr",    {31'b0, sb_if.dm_wr},    32'd0);
    check("rst_ld_stall", {31'b0, sb_if.ld_stall}, 32'd0);
    step();
    Reset = 1'b1;

    // Reset with three stores pending: they must be discarded unwritten
    sb_if.ld_valid = 1'b1;
    sb_if.ld_addr  = 32'h300;
    for (int i = 0; i < 3; i++) store(32'h100 + 32'(4 * i), 32'h1111_0000 + 32'(i), 32'h400 + 32'(4 * i));
    @(negedge CLK);
    check("pre_rst_empty", {31'b0, sb_if.empty}, 32'd0);
    Reset = 1'b0;
    step();
    Reset = 1'b1;
    sb_if.ld_valid = 1'b0;
    exp_q.delete();
    @(negedge CLK);
    check("post_rst_empty",    {31'b0, sb_if.empty},    32'd1);
    check("post_rst_st_ready", {31'b0, sb_if.st_ready}, 32'd1);
    check("post_rst_dm_wr",    {31'b0, sb_if.dm_wr},    32'd0);
    d0 = drains;
    repeat (3) step();
    check("post_rst_no_write", drains - d0, 32'd0);

    // Basic drain and one-cycle minimum latency
    sb_if.st_valid = 1'b1;
    sb_if.st_addr  = 32'h10;
    sb_if.st_data  = 32'hAAAA_0001;
    sb_if.st_pc    = 32'h1000;
    @(negedge CLK);
    check("lat_no_early_wr", {31'b0, sb_if.dm_wr}, 32'd0);
    step();
    sb_if.st_valid = 1'b0;
    @(negedge CLK);
    check("basic_dm_wr",   {31'b0, sb_if.dm_wr}, 32'd1);
    check("basic_dm_addr", sb_if.dm_addr, 32'h10);
    check("basic_dm_wd",   sb_if.dm_wd,   32'hAAAA_0001);
    step();
    @(negedge CLK);
    check("basic_empty_after", {31'b0, sb_if.empty}, 32'd1);
    check("basic_idle_dm_wr",  {31'b0, sb_if.dm_wr}, 32'd0);
    step();

    // Full buffer and backpressure under a continuous load
    sb_if.ld_valid = 1'b1;
    sb_if.ld_addr  = 32'h300;
    for (int i = 0; i < 4; i++) store(32'h40 + 32'(4 * i), 32'h3300_0000 + 32'(i), 32'h3000 + 32'(4 * i));
    @(negedge CLK);
    check("full_st_ready", {31'b0, sb_if.st_ready}, 32'd0);
    check("full_load_blocks_wr", {31'b0, sb_if.dm_wr}, 32'd0);
    step();
    sb_if.ld_valid = 1'b0;
    @(negedge CLK);
    check("full_drain_wr",       {31'b0, sb_if.dm_wr},    32'd1);
    check("full_ready_same_cyc", {31'b0, sb_if.st_ready}, 32'd0);
    step();
    @(negedge CLK);
    check("full_ready_next_cyc", {31'b0, sb_if.st_ready}, 32'd1);
    wait_drain("full");
    step();

`ifdef STORE_BUFFER_FORWARD_EN
    // Forwarding: youngest match wins, in-flight store not visible
    sb_if.ld_valid = 1'b1;
    sb_if.ld_addr  = 32'h20;
    sb_if.st_valid = 1'b1;
    sb_if.st_addr  = 32'h20;
    sb_if.st_data  = 32'd1;
    sb_if.st_pc    = 32'h500;
    @(negedge CLK);
    check("fwd_same_cycle", sb_if.ld_data, 32'd0);
    step();
    sb_if.st_data = 32'd2;
    sb_if.st_pc   = 32'h504;
    @(negedge CLK);
    check("fwd_older_entry", sb_if.ld_data, 32'd1);
    step();
    sb_if.st_valid = 1'b0;
    @(negedge CLK);
    check("fwd_youngest", sb_if.ld_data,            32'd2);
    check("fwd_no_stall", {31'b0, sb_if.ld_stall},  32'd0);
    check("fwd_ld_no_wr", {31'b0, sb_if.dm_wr},     32'd0);
    step();
    sb_if.ld_addr = 32'h24;
    @(negedge CLK);
    check("fwd_miss_data", sb_if.ld_data, 32'hDEAD_BEEF);
    check("fwd_miss_addr", sb_if.dm_addr, 32'h24);
    step();
    sb_if.ld_valid = 1'b0;
    wait_drain("fwd");
`else
    // No forwarding: a hitting load stalls until every match has drained
    sb_if.ld_valid = 1'b1;
    sb_if.ld_addr  = 32'h300;
    store(32'h20, 32'd1, 32'h500);
    store(32'h20, 32'd2, 32'h504);
    sb_if.ld_addr = 32'h20;
    n = 0;
    @(negedge CLK);
    check("stall_asserted", {31'b0, sb_if.ld_stall}, 32'd1);
    check("stall_drain_wr", {31'b0, sb_if.dm_wr},    32'd1);
    while (sb_if.ld_stall && n < 20) begin
      n++;
      @(negedge CLK);
    end
    check("stall_cycles",   n,             32'd2);
    check("stall_ld_data",  sb_if.ld_data, 32'd2);
    check("stall_ld_addr",  sb_if.dm_addr, 32'h20);
    step();
    sb_if.ld_valid = 1'b0;
    wait_drain("stall");
`endif
    step();

    // Flush: drain_req blocks new stores and drains back to back
    sb_if.ld_valid = 1'b1;
    sb_if.ld_addr  = 32'h300;
    store(32'h60, 32'h6600_0000, 32'h6000);
    store(32'h64, 32'h6600_0001, 32'h6004);
    sb_if.ld_valid  = 1'b0;
    sb_if.drain_req = 1'b1;
    @(negedge CLK);
    check("flush_wr_0", {31'b0, sb_if.dm_wr}, 32'd1);
    step();
    @(negedge CLK);
    check("flush_wr_1",     {31'b0, sb_if.dm_wr},    32'd1);
    check("flush_st_ready", {31'b0, sb_if.st_ready}, 32'd0);
    step();
    @(negedge CLK);
    check("flush_wr_2",      {31'b0, sb_if.dm_wr},    32'd0);
    check("flush_hold_rdy",  {31'b0, sb_if.st_ready}, 32'd0);
    check("flush_empty",     {31'b0, sb_if.empty},    32'd1);
    step();
    sb_if.drain_req = 1'b0;
    @(negedge CLK);
    check("flush_exit_rdy", {31'b0, sb_if.st_ready}, 32'd0);
    step();
    @(negedge CLK);
    check("run_st_ready", {31'b0, sb_if.st_ready}, 32'd1);
    step();

    // Wrap-around: ten back-to-back stores, each draining while the next enqueues
    d0 = drains;
    for (int i = 0; i < 10; i++) store(32'h80 + 32'(4 * i), 32'h5000_0000 + 32'(i), 32'h2000 + 32'(4 * i));
    wait_drain("wrap");
    check("wrap_drain_count", drains - d0, 32'd10);
    check("wrap_mem_first",   mem[8'd32],  32'h5000_0000);
    check("wrap_mem_last",    mem[8'd41],  32'h5000_0009);
    check("scoreboard_empty", exp_q.size(), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/store_buffer.md
Name: store_buffer

Overview:
- Word-store FIFO sitting directly upstream of the data memory.
- Accepts store requests from the MEM-stage datapath and drains them into the data memory's single write port in idle cycles.
- Shares that port with loads; loads have priority.
- Forwards buffered store data to loads that hit a pending address, so the pipeline sees program-order memory semantics.

Parameters:
- DEPTH, 4, number of buffered stores (power of two, ≥2)
- PTR_W, 2, log2(DEPTH)

Ports:
- CLK  in  1  clock; all state updates on posedge
- Reset  in  1  synchronous, active-low reset
- st_valid  in  1  store request this cycle
- st_ready  out  1  buffer can accept a store this cycle
- st_addr  in  32  store byte address (word aligned)
- st_data  in  32  store data
- st_pc  in  32  PC of the store instruction (carried to memory for trace)
- ld_valid  in  1  load uses the memory port this cycle
- ld_addr  in  32  load byte address
- ld_data  out  32  load result (forwarded or memory)
- ld_stall  out  1  load cannot complete this cycle (feature-dependent)
- drain_req  in  1  force full drain (halt/syscall); level
- empty  out  1  no pending stores
- dm_wr  out  1  memory write enable
- dm_addr  out  32  memory address (load address or drained store address)
- dm_wd  out  32  memory write data
- dm_pc  out  32  PC for memory trace
- dm_rd  in  32  memory combinational read data

Behaviour:
- Storage: circular buffer of {addr, data, pc}. Fields: wr_ptr, rd_ptr (PTR_W bits, wrap modulo DEPTH), count (PTR_W+1 bits).
- Reset (Reset==0 at posedge):
  - count, wr_ptr, rd_ptr = 0; state = RUN.
  - Pending entries are discarded, including mid-drain.
  - Outputs after reset: empty=1, st_ready=1, dm_wr=0, ld_stall=0.
- States:
  - RUN: st_ready = (count<DEPTH). Drains opportunistically. drain_req=1 moves to FLUSH.
  - FLUSH: st_ready=0; drains every cycle with no load. Returns to RUN when count==0 and drain_req==0; otherwise stays in FLUSH.
- Enqueue: st_valid && st_ready at posedge writes the entry at wr_ptr and increments wr_ptr.
- Drain (combinational):
  - dm_wr = (count!=0) && !ld_valid.
  - When dm_wr=1: dm_addr/dm_wd/dm_pc = entry[rd_ptr]. rd_ptr increments at the same edge the memory writes.
- Load priority: when ld_valid=1, dm_addr=ld_addr, dm_wr=0, dm_wd=0, dm_pc=0.
- Forward match: word compare addr[31:2] against all valid entries; the youngest matching entry wins. No match → ld_data=dm_rd.
- Simultaneous enqueue+drain: count unchanged; both pointers advance.
- Full (count==DEPTH): st_ready=0; a drain in that cycle does not raise st_ready until the next cycle.
- Same-cycle store and load: the load sees only entries present before this edge. The store being enqueued is never forwarded.
- Latency: a store enqueued at edge N reaches memory at edge N+1 at the earliest.
- empty = (count==0), registered-state based.

Optional Feature:
- Macro: STORE_BUFFER_FORWARD_EN
- Defined: matching loads get forwarded data; ld_stall is tied 0.
- Undefined:
  - Forward comparators are removed.
  - A load matching any pending entry asserts ld_stall=1 and does not drive dm_addr. Drain proceeds as if no load were present (dm_wr allowed).
  - ld_stall drops once no matching entry remains. ld_data=dm_rd always.

Decomposition:
- Shared package mem_pkg:
  - sb_entry_t struct {addr[31:0], data[31:0], pc[31:0]}
  - state enum {SB_RUN, SB_FLUSH}
  - constant WORD_LSB=2
- Sub-module sb_match: parameterised youngest-match priority search over DEPTH entries. Outputs hit and hit_data, walking from wr_ptr-1 back to rd_ptr.

Test Plan:
- Reset with entries pending: 3 stores queued, Reset=0 one cycle → empty=1, count=0, dm_wr=0; no memory write of those stores.
- Basic drain: store 0x10←0xAAAA_0001 at edge N, no loads → dm_wr=1, dm_addr=0x10, dm_wd=0xAAAA_0001 during cycle N+1; empty=1 after edge N+1.
- Full/backpressure: 4 stores while ld_valid held 1 → st_ready=0. Release ld_valid → one drain per cycle; st_ready=1 the cycle after the first drain.
- Forwarding (FORWARD_EN):
  - Stores 0x20←1, 0x20←2 pending, load 0x20 → ld_data=2.
  - Load 0x24 → ld_data=dm_rd.
  - Without macro: load 0x20 → ld_stall=1 until both entries drain, then ld_data=2 from memory.
- Flush: 2 pending, drain_req=1 held → st_ready=0, two consecutive dm_wr pulses. drain_req=0 → back to RUN, st_ready=1.
- Wrap-around: 10 enqueue/drain pairs through DEPTH=4 → memory receives all 10 in order, with matching dm_pc values.
